// File: rtl/clint.sv
// Core-local interruptor: msip/ssip, mtime and mtimecmp behind a simple bus.
// Optional mtime prescaler enabled by defining CLINT_PRESCALER_EN.
module clint #(
  parameter int unsigned PRESCALE = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [15:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ack,
  output logic        msip,
  output logic        ssip,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp
);

  if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
    $error("clint: PRESCALE out of range");
  end

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t state;
  state_t state_next;

  logic        accept;
  logic        wr_acc;
  logic        sel_msip;
  logic        sel_ssip;
  logic        sel_cmpl;
  logic        sel_cmph;
  logic        sel_mtl;
  logic        sel_mth;
  logic        tick;
  logic [31:0] rd_val;

  assign accept   = (state == IDLE) && (rd_en || wr_en);
  assign wr_acc   = accept && wr_en;
  assign sel_msip = (addr == 16'h0000);
  assign sel_ssip = (addr == 16'h0004);
  assign sel_cmpl = (addr == 16'h4000);
  assign sel_cmph = (addr == 16'h4004);
  assign sel_mtl  = (addr == 16'hBFF8);
  assign sel_mth  = (addr == 16'hBFFC);
  assign ack      = (state == ACK);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (rd_en || wr_en) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_msip: rd_val = {31'b0, msip};
      sel_ssip: rd_val = {31'b0, ssip};
      sel_cmpl: rd_val = mtimecmp[31:0];
      sel_cmph: rd_val = mtimecmp[63:32];
      sel_mtl:  rd_val = mtime[31:0];
      sel_mth:  rd_val = mtime[63:32];
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      rd_data  <= '0;
      msip     <= 1'b0;
      ssip     <= 1'b0;
      mtimecmp <= '1;
    end else begin
      state   <= state_next;
      // read data is the pre-write value, cleared outside ACK
      rd_data <= accept ? rd_val : '0;
      if (wr_acc && sel_msip) msip <= wr_data[0];
      if (wr_acc && sel_ssip) ssip <= wr_data[0];
      if (wr_acc && sel_cmpl) mtimecmp[31:0]  <= wr_data;
      if (wr_acc && sel_cmph) mtimecmp[63:32] <= wr_data;
    end
  end

  // a half write replaces that cycle's increment entirely
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime <= '0;
    end else if (wr_acc && sel_mtl) begin
      mtime <= {mtime[63:32], wr_data};
    end else if (wr_acc && sel_mth) begin
      mtime <= {wr_data, mtime[31:0]};
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

`ifdef CLINT_PRESCALER_EN
  logic [15:0] count;

  assign tick = (count == 16'(PRESCALE - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (wr_acc && (sel_mtl || sel_mth)) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

endmodule

// File: tb/tb_clint.sv
// Directed self-checking bench for clint.
// Hand-computed expectations; timer wrap vectors need the unprescaled build.
module tb_clint;

  logic        clock;
  logic        reset;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic        msip;
  logic        ssip;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;

  int checks = 0;
  int failures = 0;

  clint dut (
    .clock    (clock),
    .reset    (reset),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ack      (ack),
    .msip     (msip),
    .ssip     (ssip),
    .mtime    (mtime),
    .mtimecmp (mtimecmp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // drive one request, return in the ACK cycle
  task automatic start(input logic rd, input logic wr,
                       input logic [15:0] a, input logic [31:0] d);
    rd_en   = rd;
    wr_en   = wr;
    addr    = a;
    wr_data = d;
    step();
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack"}, 64'(ack), 64'd0);
    check({tag, "_rdata"}, 64'(rd_data), 64'd0);
    check({tag, "_msip"}, 64'(msip), 64'd0);
    check({tag, "_ssip"}, 64'(ssip), 64'd0);
    check({tag, "_mtime"}, mtime, 64'd0);
    check({tag, "_cmp"}, mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  initial begin
    reset   = 1'b1;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    addr    = '0;
    wr_data = '0;
    @(posedge clock);
    step();
    check_reset_state("rst");
    reset = 1'b0;

    repeat (10) @(posedge clock);
    #1;
    start(1'b1, 1'b0, 16'hBFF8, 32'h0);
    check("mt_rd_ack", 64'(ack), 64'd1);
`ifdef CLINT_PRESCALER_EN
    check("mt_rd_val", 64'(rd_data), 64'd0);
`else
    check("mt_rd_val", 64'(rd_data), 64'd10);
`endif
    step();
    check("ack_drop", 64'(ack), 64'd0);
    check("rdata_drop", 64'(rd_data), 64'd0);

    start(1'b0, 1'b1, 16'h0000, 32'h1);
    check("msip_ack", 64'(ack), 64'd1);
    check("msip_set", 64'(msip), 64'd1);
    step();
    start(1'b0, 1'b1, 16'h0004, 32'hFFFF_FFFF);
    check("ssip_set", 64'(ssip), 64'd1);
    step();
    start(1'b1, 1'b0, 16'h0004, 32'h0);
    check("ssip_rd", 64'(rd_data), 64'd1);
    step();
    start(1'b1, 1'b0, 16'h0000, 32'h0);
    check("msip_rd", 64'(rd_data), 64'd1);
    step();

    // continuous read request: every other cycle is accepted
    rd_en = 1'b1;
    addr  = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hold_ack%0d", i), 64'(ack),
            (i % 2 == 0) ? 64'd1 : 64'd0);
      check($sformatf("hold_rd%0d", i), 64'(rd_data),
            (i % 2 == 0) ? 64'hFFFF_FFFF : 64'd0);
    end
    rd_en = 1'b0;

    start(1'b1, 1'b1, 16'h4004, 32'h0);
    check("rw_old", 64'(rd_data), 64'hFFFF_FFFF);
    check("rw_cmp", mtimecmp, 64'h0000_0000_FFFF_FFFF);
    step();
    start(1'b0, 1'b1, 16'h4000, 32'h1234_5678);
    check("cmp_lo", mtimecmp, 64'h0000_0000_1234_5678);
    step();
    start(1'b1, 1'b0, 16'h4004, 32'h0);
    check("cmp_hi_rd", 64'(rd_data), 64'd0);
    step();

`ifndef CLINT_PRESCALER_EN
    start(1'b0, 1'b1, 16'hBFFC, 32'hFFFF_FFFF);
    check("mth_wr", 64'(mtime[63:32]), 64'hFFFF_FFFF);
    step();
    start(1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFE);
    check("mtl_wr", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check("mt_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    start(1'b1, 1'b0, 16'hBFFC, 32'h0);
    check("mt_max_rd", 64'(rd_data), 64'hFFFF_FFFF);
    check("mt_wrap", mtime, 64'd0);
    step();
    start(1'b1, 1'b0, 16'hBFFC, 32'h0);
    check("mt_hi_zero", 64'(rd_data), 64'd0);
    step();
    start(1'b0, 1'b1, 16'hBFF8, 32'h5);
    check("mtl_nocarry", mtime, 64'd5);
    step();
    check("mt_inc", mtime, 64'd6);
    start(1'b0, 1'b1, 16'hBFFC, 32'h7);
    check("mth_hold", mtime, 64'h0000_0007_0000_0006);
    step();
`endif

    start(1'b1, 1'b0, 16'h1234, 32'h0);
    check("unm_rd_ack", 64'(ack), 64'd1);
    check("unm_rd", 64'(rd_data), 64'd0);
    step();
    start(1'b0, 1'b1, 16'h1234, 32'hDEAD_BEEF);
    check("unm_wr_ack", 64'(ack), 64'd1);
    check("unm_wr_cmp", mtimecmp, 64'h0000_0000_1234_5678);
    reset = 1'b1;
    step();
    check_reset_state("ack_rst");

    rd_en   = 1'b0;
    wr_en   = 1'b1;
    addr    = 16'h0000;
    wr_data = 32'h1;
    step();
    wr_en = 1'b0;
    reset = 1'b0;
    check("rst_wr_msip", 64'(msip), 64'd0);
    check("rst_wr_ack", 64'(ack), 64'd0);
    step();
    check("rst_wr_noack", 64'(ack), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clint.md
CLINT -- requirements
Module: clint

Interface
REQ-001 Parameter: PRESCALE, default 100, number of clock cycles per mtime tick; used only when CLINT_PRESCALER_EN is defined, legal range 2..65535.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rd_en  input  1  bus read request.
REQ-005 wr_en  input  1  bus write request.
REQ-006 addr  input  16  byte offset of the accessed register.
REQ-007 wr_data  input  32  write data.
REQ-008 rd_data  output  32  registered read data, valid while ack=1.
REQ-009 ack  output  1  one-cycle completion pulse for an accepted request.
REQ-010 msip  output  1  machine software interrupt pending; drives the CSR block's mem_msip.
REQ-011 ssip  output  1  supervisor software interrupt pending; drives the CSR block's mem_ssip.
REQ-012 mtime  output  64  free-running timer; drives the CSR block's mem_mtime.
REQ-013 mtimecmp  output  64  timer compare value; drives the CSR block's mem_mtimecmp.

Function
REQ-014 The register map SHALL be: 0x0000 msip (bit 0, other bits read 0); 0x0004 ssip (bit 0); 0x4000 mtimecmp[31:0]; 0x4004 mtimecmp[63:32]; 0xBFF8 mtime[31:0]; 0xBFFC mtime[63:32].
REQ-015 The bus FSM SHALL have two states: IDLE and ACK.
- IDLE: (rd_en | wr_en) accepts the request and moves to ACK.
- ACK: ack=1 for exactly one cycle, then returns unconditionally to IDLE; requests present in ACK are ignored.
REQ-016 A write SHALL take effect at the accepting edge, so the new value is visible on the outputs in the ACK cycle.
REQ-017 rd_data SHALL be captured at the accepting edge from the pre-update register value, and SHALL be 0 whenever ack=0.
REQ-018 rd_en and wr_en asserted together SHALL perform the write, and rd_data SHALL return the old value.
REQ-019 An access to an unmapped offset SHALL read 0, SHALL ignore any write, and SHALL still produce ack.
REQ-020 mtime SHALL increment by 1 per tick and SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-021 A bus write to either mtime half SHALL override that cycle's increment.
- Write to the low half: mtime[63:32] is held, with no carry.
- Write to the high half: mtime[31:0] is held, with no increment.
REQ-022 Writes to the mtimecmp halves SHALL be independent; the other half is unchanged.
REQ-023 The block SHALL NOT compare mtime against mtimecmp; the MTIP comparison is performed downstream.

Reset
REQ-024 On reset the block SHALL set: FSM to IDLE, ack=0, rd_data=0, msip=0, ssip=0, mtime=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, prescaler count=0.
REQ-025 Reset asserted during ACK SHALL suppress that ack, and a write accepted in the same cycle as reset SHALL be discarded.

Configuration
REQ-026 Macro CLINT_PRESCALER_EN defined: a tick occurs when the prescaler count equals PRESCALE-1.
- The count then returns to 0; otherwise the count increments every cycle.
- Any mtime write clears the count.
REQ-027 Macro CLINT_PRESCALER_EN undefined: every clock cycle is a tick, and no prescaler state exists.

Verification
REQ-028 Release reset, idle 10 cycles, read 0xBFF8 -> ack one cycle after rd_en, rd_data=10 (macro off) or 0 (macro on, PRESCALE=100).
REQ-029 Write 0x0000=0x1, then write 0x0004=0xFFFF_FFFF -> msip=1 in the first ACK cycle, ssip=1, and a read of 0x0004 returns 0x1.
REQ-030 Write 0xBFFC=0xFFFF_FFFF and 0xBFF8=0xFFFF_FFFE (macro off) -> mtime reads 0xFFFF_FFFF_FFFF_FFFF, then 0 after the wrap, with the high half then 0.
REQ-031 Hold rd_en high continuously on 0x4000 -> ack toggles 1,0,1,0, and rd_data=0xFFFF_FFFF on each ack.
REQ-032 Assert rd_en+wr_en on 0x4004 with wr_data=0x0 -> rd_data=0xFFFF_FFFF and mtimecmp=0x0000_0000_FFFF_FFFF.
REQ-033 Write unmapped 0x1234, then assert reset during its ACK cycle -> ack=0, and all outputs equal their REQ-024 values on the next cycle.
